// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and the
// default ROM geometry used by fetch_unit and pc_reg.
package fetch_pkg;

    localparam int DEFAULT_ROM_DEPTH = 7;
    localparam int DEFAULT_ADDR_W    = 3;
    localparam int DEFAULT_DATA_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter for the fetch unit: sequential advance with wrap-around
// at the end of the ROM, and redirect with out-of-range targets clamped to 0.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int ROM_DEPTH = DEFAULT_ROM_DEPTH,
    parameter int ADDR_W    = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc
);

    // One extra bit so a ROM that fills the whole address space still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(ROM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(ROM_DEPTH - 1);

    logic [ADDR_W-1:0] next_pc;

    always_comb begin
        next_pc = pc;
        if (advance) begin
            if (jump) begin
                next_pc = ({1'b0, jump_addr} >= DEPTH_EXT) ? '0 : jump_addr;
            end else if (pc == LAST_PC) begin
                next_pc = '0;
            end else begin
                next_pc = pc + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads a synchronous ROM at pc, captures the word
// one cycle later, and holds it for decode until the valid/ready handshake.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ROM_DEPTH = DEFAULT_ROM_DEPTH,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    output logic              rom_enable,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              halt,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic              advance;
    logic [ADDR_W-1:0] pc;

    pc_reg #(
        .ROM_DEPTH (ROM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_pc_reg (
        .clock     (clock),
        .reset     (reset),
        .advance   (advance),
        .jump      (jump),
        .jump_addr (jump_addr),
        .pc        (pc)
    );

    assign rom_addr = pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // jump only reaches pc_reg through advance, so it is ignored outside a HOLD handshake.
    always_comb begin
        next_state = state;
        rom_enable = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                next_state = FETCH;
            end
            FETCH: begin
                if (!halt) begin
                    rom_enable = 1'b1;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                next_state = HOLD;
            end
            HOLD: begin
                if (instr_ready) begin
                    advance    = 1'b1;
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // instr and instr_pc keep the last word after a handshake until the next capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (state == CAPTURE) begin
            instr       <= rom_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (advance) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed and randomized fetch sequences
// checked against a transaction-level model of the program counter.
module tb_fetch_unit;

    localparam int ROM_DEPTH = 7;
    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              rom_enable;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data = '0;
    logic              halt;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    int vectors    = 0;
    int miscompares = 0;
    int model_pc   = 0;
    int last_pc    = 0;

    fetch_unit #(
        .ROM_DEPTH (ROM_DEPTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rom_enable  (rom_enable),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .halt        (halt),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clock = ~clock;

    // Registered ROM: word at addr is {1'b1, addr}, visible the cycle after a sampled enable.
    always @(posedge clock) begin
        if (rom_enable) begin
            rom_data <= {1'b1, rom_addr};
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input bit ready, input bit hlt, input bit jmp, input logic [ADDR_W-1:0] jaddr);
        instr_ready = ready;
        halt        = hlt;
        jump        = jmp;
        jump_addr   = jaddr;
        #1;
    endtask

    function automatic int next_pc_model(input int pc, input bit jmp, input int jaddr);
        if (jmp) return (jaddr >= ROM_DEPTH) ? 0 : jaddr;
        return (pc + 1) % ROM_DEPTH;
    endfunction

    function automatic int expected_word(input int pc);
        return (1 << ADDR_W) + pc;
    endfunction

    // Entered just after an edge that left the unit in FETCH at model_pc.
    task automatic fetch_one(input int hold_cycles, input int halt_cycles, input bit do_jump, input int jaddr);
        for (int i = 0; i < halt_cycles; i++) begin
            apply_stimulus(1'($urandom), 1'b1, 1'($urandom), ADDR_W'($urandom));
            check_output("halt_rom_enable", 32'(rom_enable), 32'd0);
            check_output("halt_rom_addr", 32'(rom_addr), 32'(model_pc));
            tick();
        end
        apply_stimulus(1'($urandom), 1'b0, 1'($urandom), ADDR_W'($urandom));
        check_output("fetch_rom_enable", 32'(rom_enable), 32'd1);
        check_output("fetch_rom_addr", 32'(rom_addr), 32'(model_pc));
        check_output("fetch_valid", 32'(instr_valid), 32'd0);
        tick();
        apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom), ADDR_W'($urandom));
        check_output("capture_rom_enable", 32'(rom_enable), 32'd0);
        check_output("capture_valid", 32'(instr_valid), 32'd0);
        check_output("capture_old_pc", 32'(instr_pc), 32'(last_pc));
        tick();
        for (int i = 0; i < hold_cycles; i++) begin
            apply_stimulus(1'b0, 1'($urandom), 1'($urandom), ADDR_W'($urandom));
            check_output("hold_valid", 32'(instr_valid), 32'd1);
            check_output("hold_instr", 32'(instr), 32'(expected_word(model_pc)));
            check_output("hold_instr_pc", 32'(instr_pc), 32'(model_pc));
            check_output("hold_rom_enable", 32'(rom_enable), 32'd0);
            check_output("hold_rom_addr", 32'(rom_addr), 32'(model_pc));
            tick();
        end
        apply_stimulus(1'b1, 1'b0, do_jump, ADDR_W'(jaddr));
        check_output("hs_valid", 32'(instr_valid), 32'd1);
        check_output("hs_instr", 32'(instr), 32'(expected_word(model_pc)));
        check_output("hs_instr_pc", 32'(instr_pc), 32'(model_pc));
        tick();
        last_pc  = model_pc;
        model_pc = next_pc_model(model_pc, do_jump, jaddr);
        apply_stimulus(1'($urandom), 1'b0, 1'($urandom), ADDR_W'($urandom));
        check_output("post_hs_valid", 32'(instr_valid), 32'd0);
        check_output("post_hs_rom_addr", 32'(rom_addr), 32'(model_pc));
        check_output("post_hs_rom_enable", 32'(rom_enable), 32'd1);
        check_output("post_hs_instr_pc_kept", 32'(instr_pc), 32'(last_pc));
        check_output("post_hs_instr_kept", 32'(instr), 32'(expected_word(last_pc)));
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        #2;
        check_output("reset_valid", 32'(instr_valid), 32'd0);
        check_output("reset_rom_enable", 32'(rom_enable), 32'd0);
        check_output("reset_rom_addr", 32'(rom_addr), 32'd0);
        check_output("reset_instr", 32'(instr), 32'd0);
        check_output("reset_instr_pc", 32'(instr_pc), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        check_output("idle_rom_enable", 32'(rom_enable), 32'd0);
        tick();

        $display("[TB] sequential fetch with ready held");
        for (int n = 0; n < 8; n++) begin
            fetch_one(0, 0, 1'b0, 0);
        end

        $display("[TB] jump at handshake");
        fetch_one(0, 0, 1'b1, 5);
        fetch_one(0, 0, 1'b1, 7);

        $display("[TB] decode stall");
        fetch_one(10, 0, 1'b0, 0);

        $display("[TB] halt in fetch");
        fetch_one(0, 4, 1'b0, 0);

        $display("[TB] randomized fetches");
        for (int n = 0; n < 24; n++) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 2),
                      ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
        end

        $display("[TB] reset during capture");
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        check_output("pre_reset_fetch", 32'(rom_enable), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check_output("midreset_valid", 32'(instr_valid), 32'd0);
        check_output("midreset_rom_enable", 32'(rom_enable), 32'd0);
        check_output("midreset_instr", 32'(instr), 32'd0);
        check_output("midreset_instr_pc", 32'(instr_pc), 32'd0);
        check_output("midreset_rom_addr", 32'(rom_addr), 32'd0);
        tick();
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        check_output("release_rom_enable", 32'(rom_enable), 32'd0);
        tick();
        model_pc = 0;
        last_pc  = 0;
        fetch_one(0, 0, 1'b0, 0);
        fetch_one(1, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ROM_DEPTH, default 7, number of valid program addresses (0..ROM_DEPTH-1).
REQ-002 Parameter ADDR_W, default 3, program-counter and ROM address width.
REQ-003 Parameter DATA_W, default 4, instruction width.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rom_enable  out  1  read strobe to the synchronous instruction ROM.
REQ-007 rom_addr  out  ADDR_W  ROM read address, equal to the current pc.
REQ-008 rom_data  in  DATA_W  ROM output, valid in the cycle after an edge that sampled rom_enable=1.
REQ-009 halt  in  1  level stall request, sampled in FETCH only.
REQ-010 jump  in  1  redirect request, sampled only on the consume handshake.
REQ-011 jump_addr  in  ADDR_W  redirect target.
REQ-012 instr  out  DATA_W  fetched instruction to decode.
REQ-013 instr_pc  out  ADDR_W  address that instr was fetched from.
REQ-014 instr_valid  out  1  instr/instr_pc hold a fetched instruction.
REQ-015 instr_ready  in  1  decode accepts instr when instr_valid=1 and instr_ready=1 at an edge.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, CAPTURE and HOLD.
REQ-017 IDLE SHALL drive rom_enable=0 and go to FETCH unconditionally on the next edge.
REQ-018 FETCH with halt=0 SHALL drive rom_enable=1 and rom_addr=pc, then go to CAPTURE.
REQ-019 FETCH with halt=1 SHALL drive rom_enable=0 and remain in FETCH, with pc unchanged.
REQ-020 CAPTURE SHALL drive rom_enable=0 and, on its edge, load instr<=rom_data, instr_pc<=pc and instr_valid<=1, then go to HOLD.
REQ-021 HOLD SHALL keep instr, instr_pc and instr_valid=1 stable until instr_ready=1.
REQ-022 HOLD with instr_ready=1 SHALL clear instr_valid, update pc per REQ-023/024, and go to FETCH.
REQ-023 Sequential update: pc<=pc+1, or pc<=0 when pc=ROM_DEPTH-1 (wrap-around).
REQ-024 Jump at handshake: pc<=jump_addr, or pc<=0 when jump_addr>=ROM_DEPTH; jump takes priority over REQ-023.
REQ-025 jump and jump_addr SHALL be ignored in every state other than a HOLD handshake.
REQ-026 Latency SHALL be exactly 2 edges from the FETCH edge to instr_valid=1, with peak throughput of one instruction per 3 cycles.
REQ-027 rom_addr SHALL equal pc in all states; rom_enable SHALL be combinational, derived from state and halt only.
REQ-028 instr and instr_pc SHALL be held after a handshake until the next CAPTURE edge.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0 and rom_enable=0, in any state including mid-fetch.
REQ-030 After reset is released, the first ROM read SHALL be of address 0 at the second rising edge.

Structure
REQ-031 The state enumeration, ROM_DEPTH, ADDR_W and DATA_W defaults SHALL live in shared package fetch_pkg.
REQ-032 The pc register with wrap and jump-clamp logic SHALL be the sole sub-module, pc_reg; the FSM and instruction register remain in fetch_unit.

Verification
REQ-033 The bench ROM model SHALL return {1'b1, addr} one cycle after a sampled enable, matching the ROM's registered timing.
REQ-034 Reset release with instr_ready=1 held -> instr_pc sequence 0,1,2,3,4,5,6,0, each instr = {1'b1, instr_pc}, instr_valid pulsing one cycle per 3-cycle fetch.
REQ-035 instr_ready=0 for 10 cycles while instr_valid=1 -> instr, instr_pc and instr_valid stable, rom_enable=0 throughout, no pc advance.
REQ-036 jump=1 with jump_addr=5 at handshake of pc=1 -> next instr_pc=5; jump_addr=7 -> next instr_pc=0; jump pulsed outside handshake -> ignored.
REQ-037 halt=1 for 4 cycles while in FETCH -> rom_enable=0 for 4 cycles, then fetch resumes at the same pc.
REQ-038 reset asserted during CAPTURE -> instr_valid=0 and rom_enable=0 immediately; after release, first instr_pc=0.
